// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and default sizing for the shared-adder controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_share_pkg;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Request/response bundle between the requesters and the shared-adder controller.
// Latency: n/a (wires only).
// Backpressure: req_ready grants one requester; rsp_ready stalls the response.
interface adder_share_ctrl_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_result;
   logic                     rsp_overflow;

   // controller side
   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
   );

   // requester side
   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
   );
endinterface

// File: rtl/adder.sv
// Plain combinational adder, result truncated to WIDTH bits.
// Latency: 0 cycles (combinational).
// Backpressure: none.
module adder #(
   parameter int WIDTH = 8
) (
   output logic [WIDTH-1:0] result,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b
);
   assign result = a + b;
endmodule

// File: rtl/adder_share_ctrl_arb.sv
// Round-robin pick: first set request at or after rr_ptr_i, wrapping modulo NUM_REQ.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    rr_ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    gnt_id_o
);
   logic [ID_W:0]   pos;
   logic [ID_W-1:0] idx;
   logic            found;

   // scan from the pointer upward; the first hit wins, later hits are ignored
   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      pos      = '0;
      idx      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, rr_ptr_i} + (ID_W+1)'(k);
         if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
         idx = pos[ID_W-1:0];
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_id_o   = idx;
         end
      end
   end
endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one adder between NUM_REQ requesters with round-robin arbitration.
// Latency: accept in cycle N, response valid from cycle N+2; one op per 3 cycles.
// Backpressure: response held until rsp_ready; no request accepted meanwhile.
module adder_share_ctrl
   import adder_share_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic                clk,
   input  logic                rst_n,
   adder_share_ctrl_if.slave   bus,
   output logic                busy
);
   localparam int ID_W = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [ID_W-1:0]    gid_q, gid_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               ovf_q, ovf_d;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]    arb_id;
   logic [NUM_REQ-1:0] req_rdy;
   logic [WIDTH-1:0]   sum;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req_i    (bus.req_valid),
      .rr_ptr_i (ptr_q),
      .gnt_o    (arb_gnt),
      .gnt_id_o (arb_id)
   );

   adder #(.WIDTH(WIDTH)) u_adder (
      .result (sum),
      .a      (op_a_q),
      .b      (op_b_q)
   );

   // next-state logic: grant in IDLE, capture sum in CALC, hold until taken in RESP
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      req_rdy = '0;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               req_rdy = arb_gnt;
               gid_d   = arb_id;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (arb_gnt[i]) begin
                     op_a_d = bus.req_a[i*WIDTH +: WIDTH];
                     op_b_d = bus.req_b[i*WIDTH +: WIDTH];
                  end
               end
               state_d = CALC;
            end
         end
         CALC: begin
            res_d   = sum;
            // unsigned add wrapped iff the truncated sum is below either operand
            ovf_d   = (sum < op_a_q);
            state_d = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               // the requester just served drops to lowest priority
               ptr_d   = (gid_q == ID_W'(NUM_REQ-1)) ? '0 : gid_q + ID_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset discards any in-flight op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   // grant is forced low while reset is asserted, even though state already reads IDLE
   assign bus.req_ready    = rst_n ? req_rdy : '0;
   assign bus.rsp_valid    = (state_q == RESP);
   assign bus.rsp_id       = gid_q;
   assign bus.rsp_result   = res_q;
   assign bus.rsp_overflow = ovf_q;
   assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: hand-computed vectors per scenario.
// Inputs change and outputs are sampled 1ns after the falling clock edge.
// Each scenario task compares inline and bumps vec/errs.
module tb_adder_share_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   vec  = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   adder_share_ctrl_if #(.WIDTH(8), .NUM_REQ(4)) bus ();

   adder_share_ctrl #(.WIDTH(8), .NUM_REQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   // hard stop in case a scenario wedges
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // raise req_valid[idx] until granted, then drop it one cycle later (returns in cycle N+1)
   task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b,
                        output logic [3:0] rdy, output bit to);
      bus.req_a[idx*8 +: 8] = a;
      bus.req_b[idx*8 +: 8] = b;
      bus.req_valid[idx]    = 1'b1;
      #1;
      to  = 1'b1;
      rdy = '0;
      for (int c = 0; c < 20; c++) begin
         if (bus.req_ready[idx]) begin
            to  = 1'b0;
            rdy = bus.req_ready;
            break;
         end
         @(negedge clk); #1;
      end
      @(negedge clk); #1;
      bus.req_valid[idx] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.req_valid = '1;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      vec++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL rst_req_ready got %b want 0000", bus.req_ready); end
      vec++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
      vec++; if (bus.rsp_id !== 2'd0) begin errs++; $display("FAIL rst_rsp_id got %0d want 0", bus.rsp_id); end
      vec++; if (bus.rsp_result !== 8'd0) begin errs++; $display("FAIL rst_rsp_result got %0d want 0", bus.rsp_result); end
      vec++; if (bus.rsp_overflow !== 1'b0) begin errs++; $display("FAIL rst_rsp_overflow got %b want 0", bus.rsp_overflow); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
      bus.req_valid = '0;
      rst_n = 1'b1;
      @(negedge clk); #1;
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
      vec++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL idle_req_ready got %b want 0000", bus.req_ready); end
   endtask

   task automatic test_single();
      logic [3:0] rdy;
      bit         to;
      bus.rsp_ready = 1'b1;
      issue(0, 8'd255, 8'd255, rdy, to);
      vec++; if (to !== 1'b0) begin errs++; $display("FAIL t1_accept timed out got %b want 0", to); end
      vec++; if (rdy !== 4'b0001) begin errs++; $display("FAIL t1_req_ready got %b want 0001", rdy); end
      vec++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL t1_valid_n1 got %b want 0", bus.rsp_valid); end
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL t1_busy_calc got %b want 1", busy); end
      @(negedge clk); #1;
      vec++; if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL t1_valid_n2 got %b want 1", bus.rsp_valid); end
      vec++; if (bus.rsp_id !== 2'd0) begin errs++; $display("FAIL t1_id got %0d want 0", bus.rsp_id); end
      vec++; if (bus.rsp_result !== 8'd254) begin errs++; $display("FAIL t1_result got %0d want 254", bus.rsp_result); end
      vec++; if (bus.rsp_overflow !== 1'b1) begin errs++; $display("FAIL t1_overflow got %b want 1", bus.rsp_overflow); end
      @(negedge clk); #1;
      vec++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL t1_valid_after got %b want 0", bus.rsp_valid); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL t1_busy_after got %b want 0", busy); end
   endtask

   task automatic test_wrap();
      logic [3:0] rdy;
      bit         to;
      issue(1, 8'd128, 8'd127, rdy, to);
      vec++; if (rdy !== 4'b0010 || to) begin errs++; $display("FAIL t2a_req_ready got %b want 0010", rdy); end
      @(negedge clk); #1;
      vec++; if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL t2a_valid got %b want 1", bus.rsp_valid); end
      vec++; if (bus.rsp_id !== 2'd1) begin errs++; $display("FAIL t2a_id got %0d want 1", bus.rsp_id); end
      vec++; if (bus.rsp_result !== 8'd255) begin errs++; $display("FAIL t2a_result got %0d want 255", bus.rsp_result); end
      vec++; if (bus.rsp_overflow !== 1'b0) begin errs++; $display("FAIL t2a_overflow got %b want 0", bus.rsp_overflow); end
      @(negedge clk); #1;
      issue(1, 8'd128, 8'd128, rdy, to);
      vec++; if (rdy !== 4'b0010 || to) begin errs++; $display("FAIL t2b_req_ready got %b want 0010", rdy); end
      @(negedge clk); #1;
      vec++; if (bus.rsp_id !== 2'd1) begin errs++; $display("FAIL t2b_id got %0d want 1", bus.rsp_id); end
      vec++; if (bus.rsp_result !== 8'd0) begin errs++; $display("FAIL t2b_result got %0d want 0", bus.rsp_result); end
      vec++; if (bus.rsp_overflow !== 1'b1) begin errs++; $display("FAIL t2b_overflow got %b want 1", bus.rsp_overflow); end
      @(negedge clk); #1;
   endtask

   task automatic test_all_active();
      logic [7:0] a_tab [4] = '{8'd40, 8'd100, 8'd200, 8'd255};
      logic [7:0] b_tab [4] = '{8'd2, 8'd50, 8'd100, 8'd1};
      logic [7:0] r_tab [4] = '{8'd42, 8'd150, 8'd44, 8'd0};
      logic       o_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int         k = 0;
      // restart the pointer at 0 so the expected order starts at requester 0
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*8 +: 8] = a_tab[i];
         bus.req_b[i*8 +: 8] = b_tab[i];
      end
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      #1;
      for (int c = 0; c < 40; c++) begin
         vec++; if (!$onehot0(bus.req_ready)) begin errs++; $display("FAIL t3_onehot got %b want one-hot or zero", bus.req_ready); end
         if (bus.rsp_valid) begin
            vec++; if (bus.rsp_id !== 2'(k % 4)) begin errs++; $display("FAIL t3_id[%0d] got %0d want %0d", k, bus.rsp_id, k % 4); end
            vec++; if (bus.rsp_result !== r_tab[k % 4]) begin errs++; $display("FAIL t3_result[%0d] got %0d want %0d", k, bus.rsp_result, r_tab[k % 4]); end
            vec++; if (bus.rsp_overflow !== o_tab[k % 4]) begin errs++; $display("FAIL t3_overflow[%0d] got %b want %b", k, bus.rsp_overflow, o_tab[k % 4]); end
            k++;
         end
         if (k == 6) break;
         @(negedge clk); #1;
      end
      bus.req_valid = '0;
      vec++; if (k != 6) begin errs++; $display("FAIL t3_count got %0d responses want 6", k); end
      @(negedge clk); #1;
   endtask

   task automatic test_negate();
      logic [3:0] rdy;
      bit         to;
      issue(2, 8'd37, 8'd219, rdy, to);
      vec++; if (rdy !== 4'b0100 || to) begin errs++; $display("FAIL t4a_req_ready got %b want 0100", rdy); end
      @(negedge clk); #1;
      vec++; if (bus.rsp_id !== 2'd2) begin errs++; $display("FAIL t4a_id got %0d want 2", bus.rsp_id); end
      vec++; if (bus.rsp_result !== 8'd0) begin errs++; $display("FAIL t4a_result got %0d want 0", bus.rsp_result); end
      vec++; if (bus.rsp_overflow !== 1'b1) begin errs++; $display("FAIL t4a_overflow got %b want 1", bus.rsp_overflow); end
      @(negedge clk); #1;
      issue(2, 8'd0, 8'd0, rdy, to);
      vec++; if (rdy !== 4'b0100 || to) begin errs++; $display("FAIL t4b_req_ready got %b want 0100", rdy); end
      @(negedge clk); #1;
      vec++; if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL t4b_valid got %b want 1", bus.rsp_valid); end
      vec++; if (bus.rsp_result !== 8'd0) begin errs++; $display("FAIL t4b_result got %0d want 0", bus.rsp_result); end
      vec++; if (bus.rsp_overflow !== 1'b0) begin errs++; $display("FAIL t4b_overflow got %b want 0", bus.rsp_overflow); end
      @(negedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [3:0] rdy;
      bit         to;
      bus.rsp_ready = 1'b0;
      issue(3, 8'd100, 8'd50, rdy, to);
      vec++; if (rdy !== 4'b1000 || to) begin errs++; $display("FAIL t5_req_ready got %b want 1000", rdy); end
      // a competing request waits behind the stalled response
      bus.req_a[0 +: 8] = 8'd1;
      bus.req_b[0 +: 8] = 8'd2;
      bus.req_valid[0]  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         vec++; if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL t5_hold_valid[%0d] got %b want 1", c, bus.rsp_valid); end
         vec++; if (bus.rsp_id !== 2'd3) begin errs++; $display("FAIL t5_hold_id[%0d] got %0d want 3", c, bus.rsp_id); end
         vec++; if (bus.rsp_result !== 8'd150) begin errs++; $display("FAIL t5_hold_result[%0d] got %0d want 150", c, bus.rsp_result); end
         vec++; if (bus.rsp_overflow !== 1'b0) begin errs++; $display("FAIL t5_hold_overflow[%0d] got %b want 0", c, bus.rsp_overflow); end
         vec++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL t5_hold_req_ready[%0d] got %b want 0000", c, bus.req_ready); end
      end
      bus.rsp_ready = 1'b1;
      #1;
      vec++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL t5_rel_req_ready got %b want 0000", bus.req_ready); end
      @(negedge clk); #1;
      vec++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL t5_single_hs got %b want 0", bus.rsp_valid); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL t5_idle_busy got %b want 0", busy); end
      vec++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL t5_next_grant got %b want 0001", bus.req_ready); end
      @(negedge clk); #1;
      bus.req_valid[0] = 1'b0;
      @(negedge clk); #1;
      vec++; if (bus.rsp_id !== 2'd0) begin errs++; $display("FAIL t5_next_id got %0d want 0", bus.rsp_id); end
      vec++; if (bus.rsp_result !== 8'd3) begin errs++; $display("FAIL t5_next_result got %0d want 3", bus.rsp_result); end
      @(negedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [3:0] rdy;
      bit         to;
      bus.rsp_ready = 1'b1;
      issue(2, 8'd9, 8'd9, rdy, to);
      vec++; if (rdy !== 4'b0100 || to) begin errs++; $display("FAIL t6_req_ready got %b want 0100", rdy); end
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL t6_busy_calc got %b want 1", busy); end
      bus.req_a[0 +: 8] = 8'd5;
      bus.req_b[0 +: 8] = 8'd6;
      bus.req_a[8 +: 8] = 8'd7;
      bus.req_b[8 +: 8] = 8'd8;
      bus.req_valid     = 4'b0011;
      rst_n = 1'b0;
      #1;
      vec++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL t6_rst_valid got %b want 0", bus.rsp_valid); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL t6_rst_busy got %b want 0", busy); end
      vec++; if (bus.rsp_result !== 8'd0) begin errs++; $display("FAIL t6_rst_result got %0d want 0", bus.rsp_result); end
      vec++; if (bus.rsp_overflow !== 1'b0) begin errs++; $display("FAIL t6_rst_overflow got %b want 0", bus.rsp_overflow); end
      vec++; if (bus.rsp_id !== 2'd0) begin errs++; $display("FAIL t6_rst_id got %0d want 0", bus.rsp_id); end
      vec++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL t6_rst_req_ready got %b want 0000", bus.req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      // pointer back at 0: requester 0 beats requester 1
      vec++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL t6_ptr_reset got %b want 0001", bus.req_ready); end
      vec++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL t6_no_rsp0 got %b want 0", bus.rsp_valid); end
      @(negedge clk); #1;
      bus.req_valid = '0;
      vec++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL t6_no_rsp1 got %b want 0", bus.rsp_valid); end
      @(negedge clk); #1;
      vec++; if (bus.rsp_valid !== 1'b1) begin errs++; $display("FAIL t6_valid got %b want 1", bus.rsp_valid); end
      vec++; if (bus.rsp_id !== 2'd0) begin errs++; $display("FAIL t6_id got %0d want 0", bus.rsp_id); end
      vec++; if (bus.rsp_result !== 8'd11) begin errs++; $display("FAIL t6_result got %0d want 11", bus.rsp_result); end
      @(negedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_all_active();
      test_negate();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
